// File: rtl/param_mod_counter.sv
// Runtime-limited up/down counter with wrap, saturate and one-shot modes.
// result, wrap_pulse and sat are registered; cout is the combinational terminal-count flag.
module param_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RST_LIMIT = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             wrap_pulse,
  output logic             sat,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be 2..16");
  end
  if (RST_LIMIT >= (32'd1 << WIDTH)) begin : g_bad_limit
    $error("param_mod_counter: RST_LIMIT does not fit in WIDTH bits");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] ModeSat     = 2'b01;
  localparam logic [1:0] ModeOneShot = 2'b10;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_d;
  logic             wrap_d, sat_d;
  logic [WIDTH-1:0] term, strt;
  logic             oneshot, sat_mode, can_count;

  assign term      = dir ? '0 : limit;
  assign strt      = dir ? limit : '0;
  assign oneshot   = (mode == ModeOneShot);
  assign sat_mode  = (mode == ModeSat);
  // Outside one-shot mode counting is always permitted; inside, only while running.
  assign can_count = !oneshot || (state_q == StRun);

  assign cout = (result == term);
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

  always_comb begin
    result_d = result;
    state_d  = oneshot ? state_q : StIdle;
    wrap_d   = 1'b0;
    sat_d    = sat;
    if (clr) begin
      result_d = strt;
      state_d  = StIdle;
      sat_d    = 1'b0;
    end else if (load) begin
      result_d = (load_val <= limit) ? load_val : limit;
      sat_d    = 1'b0;
    end else if (oneshot && start && (state_q != StRun)) begin
      result_d = strt;
      state_d  = StRun;
    end else if (count_en && can_count) begin
      if (result > limit) begin
        // Limit was lowered below the current count.
        if (oneshot || sat_mode) begin
          result_d = term;
        end else begin
          result_d = strt;
          wrap_d   = 1'b1;
        end
      end else if (result == term) begin
        if (oneshot) begin
          state_d = StDone;
        end else if (sat_mode) begin
          sat_d = 1'b1;
        end else begin
          result_d = strt;
          wrap_d   = 1'b1;
        end
      end else begin
        result_d = dir ? (result - One) : (result + One);
      end
    end
    if (result_d != result) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      state_q    <= StIdle;
      wrap_pulse <= 1'b0;
      sat        <= 1'b0;
    end else begin
      result     <= result_d;
      state_q    <= state_d;
      wrap_pulse <= wrap_d;
      sat        <= sat_d;
    end
  end

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter (WIDTH=4): expected outputs are queued when a step
// is driven and popped/compared one time unit after the following rising edge.
module tb_param_mod_counter;

  logic       clk = 1'b0;
  logic       rst, count_en, clr, load, dir, start;
  logic [3:0] load_val, limit;
  logic [1:0] mode;
  logic [3:0] result;
  logic       cout, wrap_pulse, sat, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] result;
    logic       cout;
    logic       wrap;
    logic       sat;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  param_mod_counter #(.WIDTH(4), .RST_LIMIT(13)) dut (
    .clk(clk), .rst(rst), .count_en(count_en), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .dir(dir), .mode(mode), .start(start),
    .result(result), .cout(cout), .wrap_pulse(wrap_pulse), .sat(sat),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string tag, int r, bit c, bit w, bit s, bit b, bit d);
    exp_t e;
    e.tag = tag; e.result = 4'(r); e.cout = c; e.wrap = w; e.sat = s; e.busy = b; e.done = d;
    return e;
  endfunction

  task automatic chk(string tag, string what, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
    end
  endtask

  // Push the expectation for this edge, clock, then pop and compare.
  task automatic tick(exp_t e);
    exp_t got;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk(got.tag, "result", int'(result), int'(got.result));
    chk(got.tag, "cout", int'(cout), int'(got.cout));
    chk(got.tag, "wrap_pulse", int'(wrap_pulse), int'(got.wrap));
    chk(got.tag, "sat", int'(sat), int'(got.sat));
    chk(got.tag, "busy", int'(busy), int'(got.busy));
    chk(got.tag, "done", int'(done), int'(got.done));
  endtask

  initial begin
    rst = 1'b1; count_en = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; limit = 4'd13; load_val = 4'd0;
    @(negedge clk);
    tick(mk("reset", 0, 0, 0, 0, 0, 0));

    // Wrap up, limit 13: 1..13, 0, 1.
    rst = 1'b0; count_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick(mk($sformatf("wrap_up%0d", i), i % 14, (i % 14) == 13, i == 14, 0, 0, 0));
    end

    // Saturate down from a load of 5, limit 9.
    mode = 2'b01; dir = 1'b1; limit = 4'd9; load = 1'b1; load_val = 4'd5; count_en = 1'b0;
    tick(mk("sat_load5", 5, 0, 0, 0, 0, 0));
    load = 1'b0; count_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(mk($sformatf("sat_dn%0d", k), (k < 5) ? 5 - k : 0, k >= 5, 0, k >= 6, 0, 0));
    end
    load = 1'b1; load_val = 4'd12; count_en = 1'b0;
    tick(mk("sat_load_clip", 9, 0, 0, 0, 0, 0));

    // Reset beats clr/load/count_en; then clr beats load in down mode.
    mode = 2'b00; dir = 1'b0; limit = 4'd13; load_val = 4'd7;
    tick(mk("load7", 7, 0, 0, 0, 0, 0));
    rst = 1'b1; clr = 1'b1; load = 1'b1; count_en = 1'b1;
    tick(mk("rst_prio", 0, 0, 0, 0, 0, 0));
    rst = 1'b0; dir = 1'b1; limit = 4'd10; load_val = 4'd4; count_en = 1'b0;
    tick(mk("clr_prio_dn", 10, 0, 0, 0, 0, 0));

    // One-shot up, limit 3; count_en ignored while idle.
    clr = 1'b0; load = 1'b0; mode = 2'b10; dir = 1'b0; limit = 4'd3; count_en = 1'b1;
    tick(mk("os_idle_ign", 10, 0, 0, 0, 0, 0));
    start = 1'b1;
    tick(mk("os_start", 0, 0, 0, 0, 1, 0));
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(mk($sformatf("os_run%0d", i), i, i == 3, 0, 0, 1, 0));
    end
    tick(mk("os_done", 3, 1, 0, 0, 0, 1));
    tick(mk("os_done_hold", 3, 1, 0, 0, 0, 1));
    start = 1'b1;
    tick(mk("os_rearm", 0, 0, 0, 0, 1, 0));
    tick(mk("os_start_ign", 1, 0, 0, 0, 1, 0));
    start = 1'b0;

    // Limit lowered below result in wrap mode, then limit 0.
    mode = 2'b00; limit = 4'd13; load = 1'b1; load_val = 4'd12; count_en = 1'b0;
    tick(mk("load12", 12, 0, 0, 0, 0, 0));
    load = 1'b0; limit = 4'd8; count_en = 1'b1;
    tick(mk("lim_drop", 0, 0, 1, 0, 0, 0));
    limit = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick(mk($sformatf("lim0_%0d", i), 0, 1, 1, 0, 0, 0));
    end

    // Reserved mode behaves as wrap.
    mode = 2'b11; limit = 4'd2;
    tick(mk("rsv1", 1, 0, 0, 0, 0, 0));
    tick(mk("rsv2", 2, 1, 0, 0, 0, 0));
    tick(mk("rsv_wrap", 0, 0, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
